// File: rtl/memory_sub_system_param.sv
// Shared memory-subsystem parameters: cache geometry, controller state encoding and request layout.
// Address layout is {tag, index}; one data word per cache line.
package memory_sub_system_param;

    localparam int TAG_LENGTH      = 10;
    localparam int INDEX_LENGTH    = 6;
    localparam int NUM_CACHE_LINES = 1 << INDEX_LENGTH;
    localparam int ADDR_WIDTH      = TAG_LENGTH + INDEX_LENGTH;
    localparam int DATA_WIDTH      = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        REFILL   = 3'd4,
        RESP     = 3'd5
    } ctrl_state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cache_req_t;

    function automatic logic [INDEX_LENGTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[INDEX_LENGTH-1:0];
    endfunction

    function automatic logic [TAG_LENGTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:INDEX_LENGTH];
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag and data arrays sharing one index; a cycle is either a write or a read, write wins.
// Read results are registered (1-cycle latency) and hold their value until the next read.
module cache_line_store
    import memory_sub_system_param::*;
(
    input  logic                    i_clk,
    input  logic [INDEX_LENGTH-1:0] i_index,
    input  logic                    i_rd_en,
    input  logic                    i_wr_en,
    input  logic [TAG_LENGTH-1:0]   i_wr_tag,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic [TAG_LENGTH-1:0]   o_rd_tag,
    output logic [DATA_WIDTH-1:0]   o_rd_data
);

    logic [TAG_LENGTH-1:0] r_tag_mem  [NUM_CACHE_LINES];
    logic [DATA_WIDTH-1:0] r_data_mem [NUM_CACHE_LINES];
    logic [TAG_LENGTH-1:0] r_rd_tag;
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag_mem[i_index]  <= i_wr_tag;
            r_data_mem[i_index] <= i_wr_data;
        end else if (i_rd_en) begin
            r_rd_tag  <= r_tag_mem[i_index];
            r_rd_data <= r_data_mem[i_index];
        end
    end

    assign o_rd_tag  = r_rd_tag;
    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller; one request in flight.
// Optional hit/miss counters are built when DM_CACHE_STATS_EN is defined.
module dm_cache_ctrl
    import memory_sub_system_param::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cpu_req_valid,
    output logic                  o_cpu_req_ready,
    input  logic                  i_cpu_req_write,
    input  logic [ADDR_WIDTH-1:0] i_cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_req_wdata,
    output logic                  o_cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] o_cpu_resp_rdata,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_write,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    output logic [DATA_WIDTH-1:0] o_mem_req_wdata,
    input  logic                  i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_resp_rdata
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]           o_hit_count,
    output logic [31:0]           o_miss_count
`endif
);

    ctrl_state_t                r_state;
    ctrl_state_t                w_state_nxt;
    cache_req_t                 r_req;
    logic [NUM_CACHE_LINES-1:0] r_valid;
    logic [DATA_WIDTH-1:0]      r_resp_rdata;
    logic [DATA_WIDTH-1:0]      r_mem_rdata;

    logic                    w_accept;
    logic                    w_hit;
    logic [INDEX_LENGTH-1:0] w_req_idx;
    logic [INDEX_LENGTH-1:0] w_array_idx;
    logic                    w_array_wr;
    logic [DATA_WIDTH-1:0]   w_array_wdata;
    logic [TAG_LENGTH-1:0]   w_rd_tag;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    assign w_accept  = (r_state == IDLE) && i_cpu_req_valid;
    assign w_req_idx = addr_index(r_req.addr);
    assign w_hit     = r_valid[w_req_idx] && (w_rd_tag == addr_tag(r_req.addr));

    // In IDLE the array is addressed straight from the port so the read lands in LOOKUP.
    assign w_array_idx = (r_state == IDLE) ? addr_index(i_cpu_req_addr) : w_req_idx;

    cache_line_store u_store (
        .i_clk     (i_clk),
        .i_index   (w_array_idx),
        .i_rd_en   (w_accept),
        .i_wr_en   (w_array_wr),
        .i_wr_tag  (addr_tag(r_req.addr)),
        .i_wr_data (w_array_wdata),
        .o_rd_tag  (w_rd_tag),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_array_wr    = 1'b0;
        w_array_wdata = r_req.wdata;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (r_req.write) begin
                    w_array_wr  = w_hit;
                    w_state_nxt = MEM_REQ;
                end else if (w_hit) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (i_mem_req_ready) w_state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (i_mem_resp_valid) w_state_nxt = r_req.write ? RESP : REFILL;
            end
            REFILL: begin
                w_array_wr    = 1'b1;
                w_array_wdata = r_mem_rdata;
                w_state_nxt   = RESP;
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_valid      <= '0;
            r_resp_rdata <= '0;
            r_mem_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req.write  <= i_cpu_req_write;
                r_req.addr   <= i_cpu_req_addr;
                r_req.wdata  <= i_cpu_req_wdata;
                r_resp_rdata <= '0;
            end
            if ((r_state == LOOKUP) && !r_req.write && w_hit) begin
                r_resp_rdata <= w_rd_data;
            end
            if ((r_state == MEM_WAIT) && i_mem_resp_valid && !r_req.write) begin
                r_mem_rdata <= i_mem_resp_rdata;
            end
            if (r_state == REFILL) begin
                r_valid[w_req_idx] <= 1'b1;
                r_resp_rdata       <= r_mem_rdata;
            end
        end
    end

`ifdef DM_CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == LOOKUP) begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (!w_hit && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`endif

    assign o_cpu_req_ready  = (r_state == IDLE);
    assign o_cpu_resp_valid = (r_state == RESP);
    assign o_cpu_resp_rdata = r_resp_rdata;

    // Memory fields are forced to zero outside MEM_REQ so the bus is quiet when idle.
    assign o_mem_req_valid = (r_state == MEM_REQ);
    assign o_mem_req_write = o_mem_req_valid && r_req.write;
    assign o_mem_req_addr  = o_mem_req_valid ? r_req.addr : '0;
    assign o_mem_req_wdata = o_mem_req_write ? r_req.wdata : '0;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: a line-level cache/memory model predicts hit/miss, memory
// traffic and load data; a negedge compare process checks the DUT against it every cycle.
module tb_dm_cache_ctrl;
    import memory_sub_system_param::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cpu_req_valid, cpu_req_ready, cpu_req_write;
    logic [ADDR_WIDTH-1:0] cpu_req_addr;
    logic [DATA_WIDTH-1:0] cpu_req_wdata;
    logic                  cpu_resp_valid;
    logic [DATA_WIDTH-1:0] cpu_resp_rdata;
    logic                  mem_req_valid, mem_req_ready, mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_rdata;
`ifdef DM_CACHE_STATS_EN
    logic [31:0]           hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_cpu_req_valid  (cpu_req_valid),
        .o_cpu_req_ready  (cpu_req_ready),
        .i_cpu_req_write  (cpu_req_write),
        .i_cpu_req_addr   (cpu_req_addr),
        .i_cpu_req_wdata  (cpu_req_wdata),
        .o_cpu_resp_valid (cpu_resp_valid),
        .o_cpu_resp_rdata (cpu_resp_rdata),
        .o_mem_req_valid  (mem_req_valid),
        .i_mem_req_ready  (mem_req_ready),
        .o_mem_req_write  (mem_req_write),
        .o_mem_req_addr   (mem_req_addr),
        .o_mem_req_wdata  (mem_req_wdata),
        .i_mem_resp_valid (mem_resp_valid),
        .i_mem_resp_rdata (mem_resp_rdata)
`ifdef DM_CACHE_STATS_EN
        ,
        .o_hit_count      (hit_count),
        .o_miss_count     (miss_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: cache lines plus backing memory.
    bit                    m_vld  [NUM_CACHE_LINES];
    logic [TAG_LENGTH-1:0] m_tag  [NUM_CACHE_LINES];
    logic [DATA_WIDTH-1:0] m_data [NUM_CACHE_LINES];
    logic [DATA_WIDTH-1:0] m_mem  [int];
    int                    m_hits = 0;
    int                    m_misses = 0;

    function automatic logic [31:0] mem_rd(input int a);
        if (m_mem.exists(a)) return m_mem[a];
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CACHE_LINES; i++) m_vld[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Expectations for the transaction in flight, read by the compare process.
    bit                    chk_en = 1'b0;
    bit                    exp_mem_req, exp_mem_write;
    logic [ADDR_WIDTH-1:0] exp_mem_addr;
    logic [DATA_WIDTH-1:0] exp_mem_wdata, exp_rdata;

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            if (mem_req_valid) begin
                if (!exp_mem_req) begin
                    check("mem_req_unexpected", 32'(mem_req_valid), 32'd0);
                end else begin
                    check("mem_req_write", 32'(mem_req_write), 32'(exp_mem_write));
                    check("mem_req_addr", 32'(mem_req_addr), 32'(exp_mem_addr));
                    if (exp_mem_write) check("mem_req_wdata", mem_req_wdata, exp_mem_wdata);
                end
            end
            if (cpu_resp_valid) check("cpu_resp_rdata", cpu_resp_rdata, exp_rdata);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(cpu_req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(cpu_resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, cpu_resp_rdata, 32'd0);
        check({tag, "_mreq_valid"}, 32'(mem_req_valid), 32'd0);
        check({tag, "_mreq_write"}, 32'(mem_req_write), 32'd0);
        check({tag, "_mreq_addr"},  32'(mem_req_addr), 32'd0);
        check({tag, "_mreq_wdata"}, mem_req_wdata, 32'd0);
`ifdef DM_CACHE_STATS_EN
        check({tag, "_hit_count"},  hit_count, 32'd0);
        check({tag, "_miss_count"}, miss_count, 32'd0);
`endif
    endtask

    // Issues one request from a negedge and acts as memory. Cycle n is sampled at the n-th negedge
    // after the acceptance edge. With abort set, reset is pulsed while the request sits in MEM_WAIT.
    task automatic do_req(input bit w, input logic [15:0] a, input logic [31:0] d,
                          input int rdy_dly, input int rsp_dly, input bit abort,
                          output bit saw_mem, output int req_cyc, output int rsp_cyc,
                          output logic [31:0] rdata_o);
        int  idx = int'(a[5:0]);
        bit  hit;
        bit  hs = 1'b0;
        int  hs_n = -1;
        int  first_v = -1;
        int  mresp_n = -1;
        int  t = 0;
        hit = m_vld[idx] && (m_tag[idx] == a[15:6]);
        exp_mem_req   = w || !hit;
        exp_mem_write = w;
        exp_mem_addr  = a;
        exp_mem_wdata = d;
        exp_rdata     = w ? 32'd0 : (hit ? m_data[idx] : mem_rd(int'(a)));
        if (hit) m_hits++; else m_misses++;
        if (w) begin
            m_mem[int'(a)] = d;
            if (hit) m_data[idx] = d;
        end else if (!hit && !abort) begin
            m_vld[idx]  = 1'b1;
            m_tag[idx]  = a[15:6];
            m_data[idx] = exp_rdata;
        end
        saw_mem = 1'b0; req_cyc = -1; rsp_cyc = -1; rdata_o = '0;

        while (!cpu_req_ready && t < 20) begin @(negedge clk); t++; end
        if (!cpu_req_ready) check("req_ready_timeout", 32'(cpu_req_ready), 32'd1);
        cpu_req_valid = 1'b1; cpu_req_write = w; cpu_req_addr = a; cpu_req_wdata = d;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            cpu_req_valid = 1'b0;
            if (mem_req_valid) begin
                saw_mem = 1'b1;
                if (first_v < 0) begin first_v = n; req_cyc = n; end
            end
            if (hs && n == hs_n + 1) check("mem_req_valid_drop", 32'(mem_req_valid), 32'd0);
            if (first_v >= 0 && !hs && !mem_req_valid) check("mem_req_valid_held", 32'(mem_req_valid), 32'd1);
            mem_req_ready = 1'b0;
            if (mem_req_valid && !hs && (n - first_v) >= rdy_dly) begin
                mem_req_ready = 1'b1; hs = 1'b1; hs_n = n;
            end
            mem_resp_valid = 1'b0;
            if (hs && n == hs_n + 1 + rsp_dly) begin
                if (abort) begin
                    reset = 1'b1;
                    @(negedge clk);
                    check_reset_outputs("mid_reset");
                    model_reset();
                    reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBADD_A7A0;
                    @(negedge clk);
                    mem_resp_valid = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        check("late_resp_valid", 32'(cpu_resp_valid), 32'd0);
                        check("late_mreq_valid", 32'(mem_req_valid), 32'd0);
                        @(negedge clk);
                    end
                    return;
                end
                mem_resp_valid = 1'b1;
                mem_resp_rdata = w ? 32'hFFFF_0000 : mem_rd(int'(a));
                mresp_n = n;
            end
            if (cpu_resp_valid) begin rsp_cyc = n; rdata_o = cpu_resp_rdata; break; end
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        if (rsp_cyc < 0) check("resp_timeout", 32'(cpu_resp_valid), 32'd1);
        else if (!exp_mem_req) check("hit_resp_cycle", rsp_cyc, 2);
        else begin
            check("mem_req_cycle", req_cyc, 2);
            check("miss_resp_cycle", rsp_cyc, w ? mresp_n + 1 : mresp_n + 2);
        end
        @(negedge clk);
        check("resp_one_cycle", 32'(cpu_resp_valid), 32'd0);
        check("ready_after_resp", 32'(cpu_req_ready), 32'd1);
`ifdef DM_CACHE_STATS_EN
        check("model_hit_count", hit_count, m_hits);
        check("model_miss_count", miss_count, m_misses);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          saw;
        int          rq, rs;
        logic [31:0] rd;
        reset = 1'b1; cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0;
        cpu_req_wdata = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        model_reset();
        m_mem[16'h0405] = 32'hDEAD_BEEF;
        m_mem[16'h0805] = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // cold load then reload
        do_req(0, 16'h0405, 0, 0, 1, 0, saw, rq, rs, rd);
        check("cold_miss_mem", 32'(saw), 32'd1);
        check("cold_rdata", rd, 32'hDEAD_BEEF);
        do_req(0, 16'h0405, 0, 0, 1, 0, saw, rq, rs, rd);
        check("reload_no_mem", 32'(saw), 32'd0);
        check("reload_cycle", rs, 2);
        check("reload_rdata", rd, 32'hDEAD_BEEF);

        // conflicting tags at index 5
        do_req(0, 16'h0805, 0, 0, 0, 0, saw, rq, rs, rd);
        check("conflict_miss", 32'(saw), 32'd1);
        check("conflict_rdata", rd, 32'hCAFE_F00D);
        do_req(0, 16'h0405, 0, 0, 3, 0, saw, rq, rs, rd);
        check("evicted_miss", 32'(saw), 32'd1);
        check("evicted_rdata", rd, 32'hDEAD_BEEF);
`ifdef DM_CACHE_STATS_EN
        check("stats_miss3", miss_count, 32'd3);
        check("stats_hit1", hit_count, 32'd1);
`endif

        // store hit, then load sees new data without memory traffic
        do_req(1, 16'h0405, 32'h1234_5678, 0, 2, 0, saw, rq, rs, rd);
        check("store_hit_mem", 32'(saw), 32'd1);
        check("store_rdata_zero", rd, 32'd0);
        do_req(0, 16'h0405, 0, 0, 1, 0, saw, rq, rs, rd);
        check("after_store_hit", 32'(saw), 32'd0);
        check("after_store_rdata", rd, 32'h1234_5678);

        // store miss does not allocate
        do_req(1, 16'h0C07, 32'hA1B2_C3D4, 1, 0, 0, saw, rq, rs, rd);
        check("store_miss_mem", 32'(saw), 32'd1);
        do_req(0, 16'h0C07, 0, 0, 1, 0, saw, rq, rs, rd);
        check("no_alloc_miss", 32'(saw), 32'd1);
        check("no_alloc_rdata", rd, 32'hA1B2_C3D4);

        // memory backpressure for 5 cycles
        do_req(0, 16'h0A09, 0, 5, 2, 0, saw, rq, rs, rd);
        check("bp_req_cycle", rq, 2);
        check("bp_rdata", rd, 32'hC0DE_0A09);

        // stray memory response while idle
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55AA_55AA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_resp_valid", 32'(cpu_resp_valid), 32'd0);
            check("idle_mreq_valid", 32'(mem_req_valid), 32'd0);
            check("idle_ready", 32'(cpu_req_ready), 32'd1);
        end
        mem_resp_valid = 1'b0;
        do_req(0, 16'h0A09, 0, 0, 1, 0, saw, rq, rs, rd);
        check("idle_then_hit", 32'(saw), 32'd0);
        check("idle_then_rdata", rd, 32'hC0DE_0A09);

        // reset while waiting for memory
        do_req(0, 16'h0B0B, 0, 0, 2, 1, saw, rq, rs, rd);
        do_req(0, 16'h0B0B, 0, 0, 1, 0, saw, rq, rs, rd);
        check("post_reset_miss", 32'(saw), 32'd1);
        check("post_reset_rdata", rd, 32'hC0DE_0B0B);
        do_req(0, 16'h0405, 0, 0, 1, 0, saw, rq, rs, rd);
        check("post_reset_cold", 32'(saw), 32'd1);
        check("post_reset_cold_rdata", rd, 32'h1234_5678);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
